// File: rtl/riscv_fetch_unit_nwide_pkg.sv
// Shared definitions for the W-lane fetch front end: reset PC and pointer sizing.
package riscv_fetch_unit_nwide_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0200;

  // Queue pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int fetch_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/riscv_fetch_unit_nwide_if.sv
// Per-lane imem request/response bundle between the fetch unit and instruction memory.
interface riscv_fetch_unit_nwide_if #(parameter int W = 2);

  logic [W-1:0]       imemreq_val;
  logic [W-1:0]       imemreq_rdy;
  logic [W-1:0][31:0] imemreq_addr;
  logic [W-1:0]       imemresp_val;
  logic [W-1:0][31:0] imemresp_data;

  modport master (
    output imemreq_val, imemreq_addr,
    input  imemreq_rdy, imemresp_val, imemresp_data
  );

  modport slave (
    input  imemreq_val, imemreq_addr,
    output imemreq_rdy, imemresp_val, imemresp_data
  );

endinterface

// File: rtl/riscv_fetch_unit_nwide_lane.sv
// Per-lane fetch tracker: outstanding credit, stale-response drop count and queue write pointer.
module riscv_fetch_unit_nwide_lane #(
  parameter int W         = 2,
  parameter int MAX_OUTST = 4,
  parameter int AW        = 3,
  parameter int LANE      = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fire,
  input  logic          resp_val,
  input  logic          redirect,
  input  logic [AW-1:0] tail_idx,
  output logic          outst_full,
  output logic          keep,
  output logic [AW-1:0] wptr
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [CW-1:0] outst, outst_nxt, drop;

  always_comb begin
    outst_nxt = outst;
    if (fire && !resp_val)
      outst_nxt = outst + CW'(1);
    else if (!fire && resp_val)
      outst_nxt = outst - CW'(1);
  end

  assign outst_full = (outst >= CW'(MAX_OUTST));
  assign keep       = resp_val && (drop == '0);

  // Everything still in flight at a redirect is stale, including words already marked for drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
      drop  <= '0;
      wptr  <= AW'(LANE);
    end else begin
      outst <= outst_nxt;
      if (redirect) begin
        drop <= outst_nxt;
        wptr <= tail_idx + AW'(LANE);
      end else begin
        if (resp_val && drop != '0)
          drop <= drop - CW'(1);
        if (keep)
          wptr <= wptr + AW'(W);
      end
    end
  end

  a_resp_credit: assert property (@(posedge clk) disable iff (!rst_n)
    resp_val |-> (outst != '0));

endmodule

// File: rtl/riscv_fetch_unit_nwide.sv
// W-lane instruction fetch front end: group-atomic issue, reorder queue, in-order delivery, redirect squash.
module riscv_fetch_unit_nwide
  import riscv_fetch_unit_nwide_pkg::*;
#(
  parameter int          W         = 2,
  parameter int          DEPTH     = 8,
  parameter int          MAX_OUTST = 4,
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  localparam int         PW        = fetch_ptr_w(DEPTH),
  localparam int         DW        = $clog2(W + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  riscv_fetch_unit_nwide_if.master    imem,
  input  logic                        redirect_val,
  input  logic [31:0]                 redirect_pc,
  output logic [W-1:0]                out_val,
  output logic [W-1:0][31:0]          out_inst,
  output logic [W-1:0][31:0]          out_pc,
  input  logic [DW-1:0]               deq_cnt,
  output logic [PW-1:0]               occupancy
);

  localparam int AW = PW - 1;

  logic [PW-1:0]      head, tail;
  logic [31:0]        fpc;
  logic [DEPTH-1:0]   valid;
  logic [31:0]        inst_q [DEPTH];
  logic [31:0]        pc_q   [DEPTH];
  logic [W-1:0]       full_l, keep_l;
  logic [W-1:0][AW-1:0] wptr_l;
  logic [AW-1:0]      slot_idx [W];
  logic               issue_ok, fire, run;

  assign occupancy = tail - head;
  // Gated by rst_n so no request is presented while reset is held.
  assign issue_ok  = rst_n && !redirect_val && ~|full_l &&
                     ((PW'(DEPTH) - occupancy) >= PW'(W));
  assign fire      = issue_ok && (&imem.imemreq_rdy);

  for (genvar i = 0; i < W; i++) begin : g_lane
    assign imem.imemreq_val[i]  = issue_ok;
    assign imem.imemreq_addr[i] = fpc + 32'(4 * i);

    riscv_fetch_unit_nwide_lane #(
      .W(W), .MAX_OUTST(MAX_OUTST), .AW(AW), .LANE(i)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .fire       (fire),
      .resp_val   (imem.imemresp_val[i]),
      .redirect   (redirect_val),
      .tail_idx   (tail[AW-1:0]),
      .outst_full (full_l[i]),
      .keep       (keep_l[i]),
      .wptr       (wptr_l[i])
    );
  end

  always_comb begin
    run = 1'b1;
    for (int j = 0; j < W; j++) begin
      slot_idx[j] = AW'(head + PW'(j));
      run         = run && (PW'(j) < occupancy) && valid[slot_idx[j]];
      out_val[j]  = run;
      out_inst[j] = inst_q[slot_idx[j]];
      out_pc[j]   = pc_q[slot_idx[j]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      fpc   <= RESET_PC;
      valid <= '0;
    end else if (redirect_val) begin
      head  <= tail;
      valid <= '0;
      fpc   <= redirect_pc & ~32'h3;
    end else begin
      head <= head + PW'(deq_cnt);
      for (int k = 0; k < W; k++)
        if (DW'(k) < deq_cnt)
          valid[AW'(head + PW'(k))] <= 1'b0;
      for (int i = 0; i < W; i++)
        if (keep_l[i])
          valid[wptr_l[i]] <= 1'b1;
      if (fire) begin
        tail <= tail + PW'(W);
        fpc  <= fpc + 32'(4 * W);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (!redirect_val && keep_l[i])
        inst_q[wptr_l[i]] <= imem.imemresp_data[i];
      if (fire)
        pc_q[AW'(tail + PW'(i))] <= fpc + 32'(4 * i);
    end
  end

  a_deq_legal: assert property (@(posedge clk) disable iff (!rst_n)
    int'(deq_cnt) <= $countones(out_val));

endmodule

// File: tb/tb_riscv_fetch_unit_nwide.sv
// Directed bench for riscv_fetch_unit_nwide (W=2, DEPTH=8, MAX_OUTST=4) with a per-lane latency memory model.
module tb_riscv_fetch_unit_nwide;

  localparam int W = 2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               redirect_val;
  logic [31:0]        redirect_pc;
  logic [W-1:0]       out_val;
  logic [W-1:0][31:0] out_inst, out_pc;
  logic [1:0]         deq_cnt;
  logic [3:0]         occupancy;

  int          errors = 0;
  int          checks = 0;
  req_t        lq [W][$];
  int          lat [W];
  bit          hold [W];
  int          cyc;
  int          want;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  riscv_fetch_unit_nwide_if #(.W(W)) imem ();

  riscv_fetch_unit_nwide #(.W(W), .DEPTH(8), .MAX_OUTST(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem),
    .redirect_val (redirect_val),
    .redirect_pc  (redirect_pc),
    .out_val      (out_val),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .deq_cnt      (deq_cnt),
    .occupancy    (occupancy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_resp();
    for (int i = 0; i < W; i++) begin
      if (!hold[i] && lq[i].size() > 0 && lq[i][0].due <= cyc) begin
        imem.imemresp_val[i]  = 1'b1;
        imem.imemresp_data[i] = ~lq[i][0].addr;
      end else begin
        imem.imemresp_val[i]  = 1'b0;
        imem.imemresp_data[i] = 32'h0;
      end
    end
  endtask

  // Called just after a falling edge with this cycle's inputs already applied.
  task automatic tick();
    int          d;
    logic        f;
    logic [W-1:0] rv;
    logic [W-1:0][31:0] a;
    d = $countones(out_val);
    if (want < d) d = want;
    deq_cnt = 2'(d);
    for (int j = 0; j < d; j++) begin
      check_val("deq_pc", out_pc[j], exp_pc);
      check_val("deq_inst", out_inst[j], ~exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
    f  = &(imem.imemreq_val & imem.imemreq_rdy);
    rv = imem.imemresp_val;
    a  = imem.imemreq_addr;
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      if (rv[i]) void'(lq[i].pop_front());
      if (f) lq[i].push_back('{addr: a[i], due: cyc + lat[i]});
    end
    cyc++;
    @(negedge clk);
    redirect_val = 1'b0;
    drive_resp();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    redirect_val = 1'b0;
    redirect_pc  = 32'h0;
    deq_cnt      = 2'd0;
    want         = 0;
    imem.imemreq_rdy = '1;
    for (int i = 0; i < W; i++) begin
      lq[i].delete();
      hold[i] = 1'b0;
      lat[i]  = 1;
    end
    cyc = 0;
    drive_resp();
    repeat (3) @(negedge clk);
    check_val("rst_reqval", 32'(imem.imemreq_val), 32'h0);
    check_val("rst_outval", 32'(out_val), 32'h0);
    check_val("rst_occ", 32'(occupancy), 32'h0);
    rst_n  = 1'b1;
    exp_pc = 32'h200;
  endtask

  initial begin
    // Steady stream, 1-cycle memory, full-rate decode
    do_reset();
    want = 2;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (n == 0) begin
        check_val("first_addr0", imem.imemreq_addr[0], 32'h200);
        check_val("first_addr1", imem.imemreq_addr[1], 32'h204);
        check_val("first_reqval", 32'(imem.imemreq_val), 32'h3);
      end
      if (n >= 2) check_val("stream_nobubble", 32'(out_val), 32'h3);
      tick();
    end

    // Lane 1 answers three cycles after lane 0
    do_reset();
    lat[1] = 4;
    for (int n = 0; n < 18; n++) begin
      #1;
      if (n == 2 || n == 4) begin
        check_val("skew_partial", 32'(out_val), 32'h1);
        check_val("skew_pc0", out_pc[0], 32'h200);
      end
      if (n == 5) begin
        check_val("skew_both", 32'(out_val), 32'h3);
        check_val("skew_pc1", out_pc[1], 32'h204);
        want = 2;
      end
      tick();
    end

    // Queue fills with no dequeue, then drains one slot per cycle
    do_reset();
    for (int n = 0; n < 8; n++) begin
      #1;
      if (n == 4) begin
        check_val("bp_occ_full", 32'(occupancy), 32'd8);
        check_val("bp_reqval_full", 32'(imem.imemreq_val), 32'h0);
        want = 1;
      end
      if (n == 5) begin
        check_val("bp_occ7", 32'(occupancy), 32'd7);
        check_val("bp_reqval_one_free", 32'(imem.imemreq_val), 32'h0);
      end
      if (n == 6) begin
        check_val("bp_occ6", 32'(occupancy), 32'd6);
        check_val("bp_reqval_resume", 32'(imem.imemreq_val), 32'h3);
      end
      tick();
    end

    // Redirect with two requests outstanding per lane
    do_reset();
    lat[0] = 3;
    lat[1] = 3;
    want   = 2;
    for (int n = 0; n < 12; n++) begin
      if (n == 2) begin
        redirect_val = 1'b1;
        redirect_pc  = 32'h1003;
      end
      #1;
      if (n == 2) begin
        check_val("redir_noissue", 32'(imem.imemreq_val), 32'h0);
        exp_pc = 32'h1000;
      end
      if (n == 3) begin
        check_val("redir_addr0", imem.imemreq_addr[0], 32'h1000);
        check_val("redir_addr1", imem.imemreq_addr[1], 32'h1004);
        check_val("redir_resume", 32'(imem.imemreq_val), 32'h3);
      end
      if (n >= 3 && n <= 6) check_val("redir_squashed", 32'(out_val), 32'h0);
      if (n == 7) begin
        check_val("redir_outval", 32'(out_val), 32'h3);
        check_val("redir_first_pc", out_pc[0], 32'h1000);
      end
      tick();
    end

    // Credit stall with responses held, redirect during the stall, then release
    do_reset();
    hold[0] = 1'b1;
    hold[1] = 1'b1;
    want    = 2;
    for (int n = 0; n < 16; n++) begin
      if (n == 5) begin
        redirect_val = 1'b1;
        redirect_pc  = 32'h3000;
      end
      #1;
      if (n == 4) check_val("credit_stall", 32'(imem.imemreq_val), 32'h0);
      if (n == 5) begin
        check_val("credit_redir_noissue", 32'(imem.imemreq_val), 32'h0);
        exp_pc  = 32'h3000;
        hold[0] = 1'b0;
        hold[1] = 1'b0;
      end
      if (n == 6) begin
        check_val("credit_still_stalled", 32'(imem.imemreq_val), 32'h0);
        check_val("credit_occ_empty", 32'(occupancy), 32'h0);
      end
      if (n == 7) begin
        check_val("credit_resume", 32'(imem.imemreq_val), 32'h3);
        check_val("credit_addr0", imem.imemreq_addr[0], 32'h3000);
      end
      if (n >= 7 && n <= 10) check_val("credit_squashed", 32'(out_val), 32'h0);
      if (n == 11) begin
        check_val("credit_outval", 32'(out_val), 32'h3);
        check_val("credit_first_pc", out_pc[0], 32'h3000);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
